lorenz_fx_integrator: RTL and testbench
=======================================

Name: lorenz_fx_integrator

Overview:
Parametrised fixed-point Lorenz attractor integrator using forward-Euler steps, with runtime sigma/rho/beta coefficients.
Replaces the unscaled, unpipelined integer Lorenz map with a 3-stage datapath, saturating arithmetic, a step counter and a valid/ready output stream.
Feeds chaotic-sequence consumers such as PRNG whiteners and DAC test-pattern paths.

Parameters:
WIDTH, 16, total bits of each signed state/coefficient word (two's complement)
FRAC, 8, fractional bits (Q(WIDTH-FRAC).FRAC)
DT_SHIFT, 6, Euler step dt = 2^-DT_SHIFT, applied as arithmetic right shift
CNT_W, 16, width of step counter / num_steps

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle request; samples x0/y0/z0/coefficients/num_steps when IDLE
x0, y0, z0  in  WIDTH  signed initial state, Q format
sigma, rho, beta  in  WIDTH  signed coefficients, Q format; sampled at start
num_steps  in  CNT_W  number of Euler steps to emit
out_valid  out  1  x/y/z hold a new state
out_ready  in  1  consumer accepts when out_valid && out_ready
x, y, z  out  WIDTH  signed current state
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last handshake, or after LOAD when num_steps==0
ovf  out  1  sticky: any saturation since last accepted start

Behaviour:
- Reset: the only reset is asynchronous, active-high, and it forces state IDLE.
  x, y, z, out_valid, busy, done, ovf, counter and all pipeline registers clear to 0.
- FSM: IDLE -> LOAD -> S1 -> S2 -> S3 -> EMIT -> (S1 | FIN) -> IDLE.
- IDLE: start=1 latches inputs, clears ovf and moves to LOAD. start in any other state is ignored.
- LOAD: x/y/z <= x0/y0/z0 and cnt <= num_steps. If num_steps==0, go to FIN; no out_valid.
- S1: d_yx = y-x and d_rz = rho-z, each WIDTH+1 bits (no overflow).
- S2: four products, each full-width then >>> FRAC then saturated to WIDTH:
  p_s = sigma*d_yx, p_r = x*d_rz, p_xy = x*y, p_b = beta*z.
- S3: derivatives dx = p_s, dy = sat(p_r - y), dz = sat(p_xy - p_b).
  Update x <= sat(x + (dx >>> DT_SHIFT)), same for y and z. Decrement cnt.
- EMIT: out_valid=1. x/y/z and out_valid are held stable until out_ready=1.
  On the handshake: cnt!=0 -> S1, cnt==0 -> FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE. x/y/z keep the final state.
- Latency: 3 cycles compute per step plus 1 EMIT cycle minimum. Throughput is 1 state per 4 cycles with out_ready tied high.
- Saturation clamps to +(2^(WIDTH-1)-1) or -2^(WIDTH-1).
- Every clamp, intermediate or final, sets ovf. ovf stays set until the next accepted start.
- Shifts are arithmetic and truncate toward -inf (default build).
- out_ready while out_valid=0 has no effect.
- Reset mid-step aborts immediately. No done pulse is produced.

Optional Feature:
LORENZ_ROUND_EN:
- Defined: every >>> FRAC and >>> DT_SHIFT adds half-LSB before shifting (round-half-up), then saturates.
- Undefined: plain truncation toward -inf.
- Interface and latency are identical in both builds.

Decomposition:
- Package lorenz_pkg:
  - state enum (IDLE, LOAD, S1, S2, S3, EMIT, FIN)
  - function sat_w (wide->WIDTH with overflow flag)
  - Q-format helper constants (ONE = 1<<FRAC, MAXV, MINV)
- One sub-module lorenz_fx_mul: signed WIDTH x (WIDTH+1) multiply, FRAC shift, optional rounding, saturate, ovf out. Four instances in S2.

Test Plan:
All scenarios use WIDTH=16, FRAC=8, DT_SHIFT=6, sigma=0x0A00, rho=0x1C00, beta=0x02AB, out_ready=1 unless stated.
- Fixed point at origin: x0=y0=z0=0, num_steps=4 -> 4 handshakes with x=y=z=0, then done pulse; ovf=0; busy high 18 cycles.
- Single step: x0=0x0100, y0=0, z0=0, num_steps=1 -> out x=0x00D8, y=0x0070, z=0x0000, then done.
- Backpressure: as above with num_steps=3 and out_ready=0 for 5 cycles at first EMIT -> out_valid stays 1, x/y/z unchanged; step 2 begins only after the handshake.
- Saturation: x0=y0=0x7F00, z0=0, num_steps=1 -> p_xy clamps to 0x7FFF, ovf=1 and stays 1 until next start.
- Zero steps / start ignored: num_steps=0 -> done 2 cycles after start, no out_valid. A start pulsed while busy in another run -> no effect on cnt or state.
- Async reset mid-run: assert rst during S2 -> x/y/z/out_valid/busy/ovf read 0 before the next clk edge; no done pulse; a new start after release runs normally.

Source files
------------

// File: rtl/lorenz_pkg.sv
//------------------------------------------------------------------------------
// Module : lorenz_pkg
// Brief  : FSM states, Q-format constants and saturation helper for the
//          Lorenz integrator.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package lorenz_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4,
    EMIT = 3'd5,
    FIN  = 3'd6
  } state_e;

  // Q8.8 reference constants for the default 16-bit build
  localparam int LZ_WIDTH = 16;
  localparam int LZ_FRAC  = 8;
  localparam logic [LZ_WIDTH-1:0] ONE  = LZ_WIDTH'(1 << LZ_FRAC);
  localparam logic [LZ_WIDTH-1:0] MAXV = {1'b0, {(LZ_WIDTH-1){1'b1}}};
  localparam logic [LZ_WIDTH-1:0] MINV = {1'b1, {(LZ_WIDTH-1){1'b0}}};

  // Clamp a sign-extended value into a w-bit two's complement range.
  function automatic logic [63:0] sat_w(input logic signed [63:0] v,
                                        input int unsigned        w,
                                        output logic              ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (w - 1));
    ovf   = 1'b0;
    sat_w = v;
    if (v > hi) begin
      sat_w = hi;
      ovf   = 1'b1;
    end else if (v < lo) begin
      sat_w = lo;
      ovf   = 1'b1;
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/lorenz_fx_mul.sv
//------------------------------------------------------------------------------
// Module : lorenz_fx_mul
// Brief  : Signed WIDTH x (WIDTH+1) fixed-point multiply, >>> FRAC, saturate.
//          LORENZ_ROUND_EN selects round-half-up instead of truncation.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module lorenz_fx_mul
  import lorenz_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH:0]   b_i,
  output logic signed [WIDTH-1:0] p_o,
  output logic                    ovf_o
);

  localparam int PW = 2*WIDTH + 1;

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_shift;

  assign w_prod = PW'(a_i) * PW'(b_i);

`ifdef LORENZ_ROUND_EN
  assign w_shift = (w_prod + (PW'(1) <<< (FRAC - 1))) >>> FRAC;
`else
  assign w_shift = w_prod >>> FRAC;
`endif

  always_comb begin
    ovf_o = 1'b0;
    p_o   = WIDTH'(sat_w(64'(w_shift), WIDTH, ovf_o));
  end

endmodule

`default_nettype wire

// File: rtl/lorenz_fx_integrator.sv
//------------------------------------------------------------------------------
// Module : lorenz_fx_integrator
// Brief  : Forward-Euler fixed-point Lorenz integrator, 3-stage datapath with
//          valid/ready output. Optional macro: LORENZ_ROUND_EN (rounded shifts).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module lorenz_fx_integrator
  import lorenz_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int DT_SHIFT = 6,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] y0,
  input  logic signed [WIDTH-1:0] z0,
  input  logic signed [WIDTH-1:0] sigma,
  input  logic signed [WIDTH-1:0] rho,
  input  logic signed [WIDTH-1:0] beta,
  input  logic [CNT_W-1:0]        num_steps,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y,
  output logic signed [WIDTH-1:0] z,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf
);

  localparam int W1 = WIDTH + 1;

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] x_q, y_q, z_q;
  logic signed [WIDTH-1:0] x0_q, y0_q, z0_q;
  logic signed [WIDTH-1:0] sigma_q, rho_q, beta_q;
  logic [CNT_W-1:0]        n_q, cnt_q;
  logic signed [W1-1:0]    dyx_q, drz_q;
  logic signed [WIDTH-1:0] ps_q, pr_q, pxy_q, pb_q;
  logic                    busy_q, done_q, ovf_q;

  logic signed [WIDTH-1:0] w_ps, w_pr, w_pxy, w_pb;
  logic                    w_ovf_ps, w_ovf_pr, w_ovf_pxy, w_ovf_pb;
  logic signed [W1-1:0]    w_y_ext, w_z_ext;
  logic signed [WIDTH-1:0] w_dy, w_dz, w_x_n, w_y_n, w_z_n;
  logic                    w_ovf_dy, w_ovf_dz, w_ovf_x, w_ovf_y, w_ovf_z;

  // One Euler update: s + (d >>> DT_SHIFT), clamped to WIDTH.
  function automatic logic signed [WIDTH-1:0] euler(input  logic signed [WIDTH-1:0] s,
                                                    input  logic signed [WIDTH-1:0] d,
                                                    output logic                    o);
    logic signed [W1-1:0] inc;
    logic signed [W1-1:0] sum;
`ifdef LORENZ_ROUND_EN
    inc = (W1'(d) + (W1'(1) <<< (DT_SHIFT - 1))) >>> DT_SHIFT;
`else
    inc = W1'(d) >>> DT_SHIFT;
`endif
    sum = W1'(s) + inc;
    o   = 1'b0;
    return WIDTH'(sat_w(64'(sum), WIDTH, o));
  endfunction

  assign w_y_ext = W1'(y_q);
  assign w_z_ext = W1'(z_q);

  lorenz_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_s (
    .a_i(sigma_q), .b_i(dyx_q),   .p_o(w_ps),  .ovf_o(w_ovf_ps)
  );
  lorenz_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_r (
    .a_i(x_q),     .b_i(drz_q),   .p_o(w_pr),  .ovf_o(w_ovf_pr)
  );
  lorenz_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_xy (
    .a_i(x_q),     .b_i(w_y_ext), .p_o(w_pxy), .ovf_o(w_ovf_pxy)
  );
  lorenz_fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_b (
    .a_i(beta_q),  .b_i(w_z_ext), .p_o(w_pb),  .ovf_o(w_ovf_pb)
  );

  // S3 derivatives and next state; dx is p_s unchanged
  always_comb begin
    w_ovf_dy = 1'b0;
    w_ovf_dz = 1'b0;
    w_ovf_x  = 1'b0;
    w_ovf_y  = 1'b0;
    w_ovf_z  = 1'b0;
    w_dy  = WIDTH'(sat_w(64'(W1'(pr_q) - W1'(y_q)), WIDTH, w_ovf_dy));
    w_dz  = WIDTH'(sat_w(64'(W1'(pxy_q) - W1'(pb_q)), WIDTH, w_ovf_dz));
    w_x_n = euler(x_q, ps_q, w_ovf_x);
    w_y_n = euler(y_q, w_dy, w_ovf_y);
    w_z_n = euler(z_q, w_dz, w_ovf_z);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = (n_q == '0) ? FIN : S1;
      S1:      state_d = S2;
      S2:      state_d = S3;
      S3:      state_d = EMIT;
      EMIT:    if (out_ready) state_d = (cnt_q == '0) ? FIN : S1;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;  y_q    <= '0;  z_q    <= '0;
      x0_q    <= '0;  y0_q   <= '0;  z0_q   <= '0;
      sigma_q <= '0;  rho_q  <= '0;  beta_q <= '0;
      n_q     <= '0;  cnt_q  <= '0;
      dyx_q   <= '0;  drz_q  <= '0;
      ps_q    <= '0;  pr_q   <= '0;  pxy_q  <= '0;  pb_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FIN);
      unique case (state_q)
        IDLE: if (start) begin
          x0_q    <= x0;    y0_q  <= y0;   z0_q   <= z0;
          sigma_q <= sigma; rho_q <= rho;  beta_q <= beta;
          n_q     <= num_steps;
          ovf_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
        LOAD: begin
          x_q   <= x0_q;
          y_q   <= y0_q;
          z_q   <= z0_q;
          cnt_q <= n_q;
        end
        S1: begin
          dyx_q <= W1'(y_q) - W1'(x_q);
          drz_q <= W1'(rho_q) - W1'(z_q);
        end
        S2: begin
          ps_q  <= w_ps;
          pr_q  <= w_pr;
          pxy_q <= w_pxy;
          pb_q  <= w_pb;
          ovf_q <= ovf_q | w_ovf_ps | w_ovf_pr | w_ovf_pxy | w_ovf_pb;
        end
        S3: begin
          x_q   <= w_x_n;
          y_q   <= w_y_n;
          z_q   <= w_z_n;
          cnt_q <= cnt_q - CNT_W'(1);
          ovf_q <= ovf_q | w_ovf_dy | w_ovf_dz | w_ovf_x | w_ovf_y | w_ovf_z;
        end
        FIN:     busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = (state_q == EMIT);
  assign x         = x_q;
  assign y         = y_q;
  assign z         = z_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ovf       = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_lorenz_fx_integrator.sv
//------------------------------------------------------------------------------
// Module : tb_lorenz_fx_integrator
// Brief  : Directed self-checking bench for lorenz_fx_integrator (Q8.8 build).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lorenz_fx_integrator;
  import lorenz_pkg::*;

`ifdef LORENZ_ROUND_EN
  localparam logic [15:0] E2_X  = 16'h00C8, E2_Y  = 16'h00CD, E2_Z = 16'h0001;
  localparam logic [15:0] SAT_Y = 16'h7F04, SAT_Z = 16'h0200, NEG_X = 16'h8200;
`else
  localparam logic [15:0] E2_X  = 16'h00C7, E2_Y  = 16'h00CC, E2_Z = 16'h0001;
  localparam logic [15:0] SAT_Y = 16'h7F03, SAT_Z = 16'h01FF, NEG_X = 16'h81FF;
`endif

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
  logic [15:0] x0 = '0, y0 = '0, z0 = '0;
  logic [15:0] sigma = 16'h0A00, rho = 16'h1C00, beta = 16'h02AB;
  logic [15:0] num_steps = '0;
  logic        out_valid, busy, done, ovf;
  logic [15:0] x, y, z;

  int n_tests = 0, n_fail = 0;
  int hs_n = 0, done_n = 0, busy_n = 0, valid_n = 0;
  logic [15:0] hs_x [8];
  logic [15:0] hs_y [8];
  logic [15:0] hs_z [8];
  logic [15:0] sx, sy, sz, nz;
  int d0;

  always #5 clk = ~clk;

  lorenz_fx_integrator #(.WIDTH(16), .FRAC(8), .DT_SHIFT(6), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .z0(z0),
    .sigma(sigma), .rho(rho), .beta(beta),
    .num_steps(num_steps),
    .out_valid(out_valid), .out_ready(out_ready),
    .x(x), .y(y), .z(z),
    .busy(busy), .done(done), .ovf(ovf)
  );

  // Inputs change at posedge+1, so the negedge view is what the next edge sees
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (hs_n < 8) begin
        hs_x[hs_n] = x;
        hs_y[hs_n] = y;
        hs_z[hs_n] = z;
      end
      hs_n++;
    end
    if (done)      done_n++;
    if (busy)      busy_n++;
    if (out_valid) valid_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    hs_n = 0; done_n = 0; busy_n = 0; valid_n = 0;
  endtask

  task automatic do_start(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] n);
    x0 = a; y0 = b; z0 = c; num_steps = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_valid_tmo"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int s = done_n;
    int k = 0;
    while (done_n == s && k < 200) begin
      tick();
      k++;
    end
    chk({tag, "_done_tmo"}, 32'(done_n - s), 32'd1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_xyz",   32'({x, y, z}), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    rst = 1'b0;
    tick();

    // fixed point at the origin
    clr();
    do_start(16'h0000, 16'h0000, 16'h0000, 16'd4);
    wait_done("org");
    tick();
    chk("org_hs",    32'(hs_n), 32'd4);
    chk("org_valid", 32'(valid_n), 32'd4);
    chk("org_busy",  32'(busy_n), 32'd18);
    chk("org_ovf",   32'(ovf), 32'd0);
    nz = '0;
    for (int i = 0; i < 4; i++) nz = nz | hs_x[i] | hs_y[i] | hs_z[i];
    chk("org_xyz", 32'(nz), 32'd0);

    // single step from (1,0,0)
    clr();
    do_start(ONE, 16'h0000, 16'h0000, 16'd1);
    wait_valid("one");
    chk("one_x", 32'(x), 32'h00D8);
    chk("one_y", 32'(y), 32'h0070);
    chk("one_z", 32'(z), 32'h0000);
    wait_done("one");
    chk("one_hs",   32'(hs_n), 32'd1);
    chk("one_busy", 32'(busy), 32'd0);
    chk("one_hold", 32'(x), 32'h00D8);

    // backpressure on first EMIT
    clr();
    out_ready = 1'b0;
    do_start(ONE, 16'h0000, 16'h0000, 16'd3);
    wait_valid("bp");
    sx = x; sy = y; sz = z;
    chk("bp_x1", 32'(sx), 32'h00D8);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      chk("bp_stall_xyz", 32'({x, y, z}), 32'({sx, sy, sz}));
    end
    chk("bp_no_hs", 32'(hs_n), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_gap_valid", 32'(out_valid), 32'd0);
    end
    tick();
    chk("bp_s2_valid", 32'(out_valid), 32'd1);
    chk("bp_s2_x", 32'(x), 32'(E2_X));
    chk("bp_s2_y", 32'(y), 32'(E2_Y));
    chk("bp_s2_z", 32'(z), 32'(E2_Z));
    wait_done("bp");
    chk("bp_hs", 32'(hs_n), 32'd3);

    // positive saturation; ovf sticky
    clr();
    do_start(MAXV & ~(ONE - 16'd1), MAXV & ~(ONE - 16'd1), 16'h0000, 16'd1);
    wait_done("sat");
    chk("sat_x",   32'(hs_x[0]), 32'h7F00);
    chk("sat_y",   32'(hs_y[0]), 32'(SAT_Y));
    chk("sat_z",   32'(hs_z[0]), 32'(SAT_Z));
    chk("sat_ovf", 32'(ovf), 32'd1);
    repeat (3) tick();
    chk("sat_ovf_sticky", 32'(ovf), 32'd1);

    // negative saturation; new start clears ovf
    clr();
    do_start(MINV, 16'h0000, 16'h0000, 16'd1);
    chk("neg_ovf_clr", 32'(ovf), 32'd0);
    wait_done("neg");
    chk("neg_x",   32'(hs_x[0]), 32'(NEG_X));
    chk("neg_y",   32'(hs_y[0]), 32'hFE00);
    chk("neg_z",   32'(hs_z[0]), 32'h0000);
    chk("neg_ovf", 32'(ovf), 32'd1);

    // zero steps: done two cycles after start, no output
    clr();
    do_start(ONE, 16'h0000, 16'h0000, 16'd0);
    chk("zero_done_load", 32'(done), 32'd0);
    tick();
    chk("zero_done_fin", 32'(done), 32'd0);
    chk("zero_x_loaded", 32'(x), 32'(ONE));
    tick();
    chk("zero_done", 32'(done), 32'd1);
    tick();
    chk("zero_done_pulse", 32'(done), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_valid", 32'(valid_n), 32'd0);

    // start while busy is ignored
    clr();
    do_start(ONE, 16'h0000, 16'h0000, 16'd1);
    tick();
    tick();
    x0 = 16'h7F00; num_steps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("ign");
    chk("ign_hs", 32'(hs_n), 32'd1);
    chk("ign_x",  32'(hs_x[0]), 32'h00D8);
    repeat (4) tick();
    chk("ign_done_n", 32'(done_n), 32'd1);
    chk("ign_busy",   32'(busy), 32'd0);

    // asynchronous reset in S2 of step 2
    clr();
    do_start(16'h7F00, 16'h7F00, 16'h0000, 16'd2);
    chk("ar_ovf_clr", 32'(ovf), 32'd0);
    wait_valid("ar");
    tick();
    tick();
    chk("ar_ovf_pre", 32'(ovf), 32'd1);
    chk("ar_busy_pre", 32'(busy), 32'd1);
    d0 = done_n;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ar_xyz",   32'({x, y, z}), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_busy",  32'(busy), 32'd0);
    chk("ar_ovf",   32'(ovf), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("ar_no_done", 32'(done_n - d0), 32'd0);
    clr();
    do_start(ONE, 16'h0000, 16'h0000, 16'd1);
    wait_done("ar_rerun");
    chk("ar_rerun_x", 32'(hs_x[0]), 32'h00D8);
    chk("ar_rerun_y", 32'(hs_y[0]), 32'h0070);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
